// File: rtl/fifo_frame_reader.sv
// Read-side frame consumer: pops FRAME_LEN samples from the sample FIFO and
// streams them out on a registered valid/ready port, aborting stalled frames.
module fifo_frame_reader #(
  parameter int DATA_SIZE = 4,
  parameter int FRAME_LEN = 4,
  parameter int TIMEOUT   = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 start_i,
  input  logic                 fifo_empty_i,
  input  logic [DATA_SIZE-1:0] fifo_data_i,
  output logic                 fifo_inc_o,
  output logic [DATA_SIZE-1:0] data_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 last_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic                 timeout_o,
  output logic [1:0]           dbg_state_o
);

  typedef enum logic [1:0] {IDLE = 2'd0, COLLECT = 2'd1, DRAIN = 2'd2} state_t;

  localparam int RW = $clog2(FRAME_LEN + 1);
  localparam int IW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [RW-1:0] FRAME_INIT = RW'(FRAME_LEN);
  localparam logic [IW-1:0] IDLE_LAST  = IW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
  localparam logic [IW-1:0] IDLE_MAX   = '1;

  state_t               r_state;
  logic [RW-1:0]        r_remaining;
  logic [IW-1:0]        r_idle_cnt;
  logic [DATA_SIZE-1:0] r_data;
  logic                 r_valid;
  logic                 r_last;
  logic                 r_busy;
  logic                 r_done;
  logic                 r_timeout;

  logic w_pop;
  logic w_hs;
  logic w_idle;

  // Output stream: a sample transfers on any edge where valid_o & ready_i;
  // valid_o never drops and data_o/last_o never change until that happens.
  assign w_hs   = r_valid & ready_i;
  assign w_pop  = !rst_i && (r_state == COLLECT) && !fifo_empty_i &&
                  (!r_valid || ready_i) && (r_remaining != '0);
  assign w_idle = fifo_empty_i & !r_valid;

  assign fifo_inc_o  = w_pop;
  assign data_o      = r_data;
  assign valid_o     = r_valid;
  assign last_o      = r_last;
  assign busy_o      = r_busy;
  assign done_o      = r_done;
  assign timeout_o   = r_timeout;
  assign dbg_state_o = r_state;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state     <= IDLE;
      r_remaining <= '0;
      r_idle_cnt  <= '0;
      r_data      <= '0;
      r_valid     <= 1'b0;
      r_last      <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start_i) begin
            r_state     <= COLLECT;
            r_remaining <= FRAME_INIT;
            r_idle_cnt  <= '0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b1;
          end
        end
        COLLECT: begin
          if (w_pop) begin
            r_data      <= fifo_data_i;
            r_valid     <= 1'b1;
            r_last      <= (r_remaining == RW'(1));
            r_remaining <= r_remaining - RW'(1);
            r_idle_cnt  <= '0;
            if (r_remaining == RW'(1)) r_state <= DRAIN;
          end else begin
            if (w_hs) begin
              r_valid <= 1'b0;
              r_last  <= 1'b0;
            end
            // Only counts while nothing is pending, so an abort never drops a sample.
            if ((TIMEOUT > 0) && w_idle) begin
              if (r_idle_cnt == IDLE_LAST) begin
                r_state   <= IDLE;
                r_timeout <= 1'b1;
                r_busy    <= 1'b0;
              end else if (r_idle_cnt != IDLE_MAX) begin
                r_idle_cnt <= r_idle_cnt + IW'(1);
              end
            end
          end
        end
        DRAIN: begin
          if (w_hs && r_last) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fifo_frame_reader.md
# fifo_frame_reader

Read-side consumer for the sample FIFO. On a start request it pops exactly FRAME_LEN samples from the FIFO read port and presents them on a valid/ready output stream, flagging the final sample with last_o. It runs entirely in the FIFO read clock domain, between the read pointer/RAM read port and the downstream sample sink (display or host link). A no-data timeout aborts stalled frames.

## Interface
- DATA_SIZE, 4: sample width in bits.
- FRAME_LEN, 4: samples per frame; must be ≥1.
- TIMEOUT, 8: idle cycles before a frame is aborted; 0 disables the timeout.
- clk_i  in  1  FIFO read clock; the only clock.
- rst_i  in  1  synchronous, active-high reset.
- start_i  in  1  one-cycle frame request; ignored while busy_o=1.
- fifo_empty_i  in  1  FIFO empty flag; read pointer domain, registered.
- fifo_data_i  in  DATA_SIZE  head-of-FIFO data; valid whenever fifo_empty_i=0.
- fifo_inc_o  out  1  pop strobe to the read pointer inc_i; combinational.
- data_o  out  DATA_SIZE  output sample, registered.
- valid_o  out  1  data_o holds an unaccepted sample.
- ready_i  in  1  sink accepts data_o when valid_o&ready_i.
- last_o  out  1  data_o is the final sample of the frame.
- busy_o  out  1  frame in progress.
- done_o  out  1  one-cycle pulse: frame completed successfully.
- timeout_o  out  1  sticky: last frame aborted by timeout; cleared by the next accepted start_i.

## Operation
- States: IDLE, COLLECT, DRAIN.
- IDLE: if start_i=1, go to COLLECT. Load remaining=FRAME_LEN. Clear idle_cnt and timeout_o. Set busy_o=1.
- pop = (state==COLLECT) & !fifo_empty_i & (!valid_o | ready_i) & (remaining≠0). fifo_inc_o=pop.
- On pop:
  - data_o←fifo_data_i, valid_o←1, remaining←remaining−1.
  - last_o←(remaining==1).
  - idle_cnt←0.
  - If remaining==1, go to DRAIN.
- Handshake valid_o&ready_i without a pop in the same cycle: valid_o←0, last_o←0.
- Handshake with a simultaneous pop: the new sample replaces the old one. Throughput is one sample per cycle.
- DRAIN: no pops. On valid_o&ready_i&last_o:
  - valid_o←0, last_o←0.
  - Go to IDLE, busy_o←0, done_o←1 for one cycle.
- Timeout (TIMEOUT>0, COLLECT only):
  - idle_cnt increments each cycle in which fifo_empty_i=1 and valid_o=0.
  - idle_cnt clears on any pop.
  - When idle_cnt reaches TIMEOUT−1 and the condition still holds, go to IDLE with timeout_o←1, busy_o←0, no done_o.
  - The timeout never fires while a sample is pending on the output, so no accepted-by-FIFO sample is dropped.
- Counter widths:
  - remaining: $clog2(FRAME_LEN+1) bits.
  - idle_cnt: $clog2(TIMEOUT+1) bits, saturating.
- start_i during COLLECT or DRAIN is ignored, including the cycle of the final handshake.

## Timing
- Reset values: fifo_inc_o=0, data_o=0, valid_o=0, last_o=0, busy_o=0, done_o=0, timeout_o=0, state IDLE.
- rst_i mid-frame: outputs return to reset values on the next edge. Samples already popped are lost; the FIFO is not rewound.
- start_i at edge n: busy_o=1 after edge n. The first pop can occur in cycle n+1.
- Pop in cycle k: data_o/valid_o update at edge k. The read pointer advances at edge k. fifo_empty_i reflects the pop from cycle k+1, so back-to-back pops are legal.
- fifo_data_i is sampled only in a pop cycle.
- Final handshake at edge m: done_o=1 and busy_o=0 during cycle m+1. A new start_i is accepted from cycle m+1.
- ready_i may toggle freely. data_o, valid_o and last_o are stable while valid_o=1 & ready_i=0.

## Test plan
- Basic frame: FIFO preloaded with 1,2,3,4, ready_i=1, pulse start_i.
  - fifo_inc_o high for 4 consecutive cycles.
  - data_o 1,2,3,4 on consecutive cycles; last_o only with 4.
  - done_o pulses once; busy_o falls with it.
- Backpressure: same data, ready_i alternating 0/1 starting at 0.
  - No pop while valid_o=1 & ready_i=0.
  - Each of 1,2,3,4 is held until accepted; no duplicates or drops.
- Starved FIFO: write samples 5,6,7,8 one every 6 read cycles, TIMEOUT=8.
  - Frame completes with 5,6,7,8.
  - timeout_o=0 and done_o pulses.
- Timeout: start_i with the FIFO holding 2 samples and no further writes, ready_i=1.
  - Two samples are output.
  - After 8 idle cycles: busy_o=0, timeout_o=1, done_o never asserts.
  - The next start_i clears timeout_o.
- Reset mid-frame: assert rst_i after the 2nd pop.
  - All outputs are 0 the next cycle.
  - start_i then reads the remaining FIFO contents from the current head.
- Start while busy: pulse start_i in COLLECT and on the final-handshake cycle.
  - Exactly one frame of 4 samples and one done_o pulse.
